// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: memory read handshake, decoded-instruction hand-off
// to the execute stage, and the PC redirect path.
interface instr_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_data;
  logic [7:0]  opcode;
  logic [7:0]  operand_lo;
  logic [7:0]  operand_hi;
  logic [1:0]  instr_len;
  logic        instr_valid;
  logic        instr_ack;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] pc;

  modport master (
    output mem_addr, mem_rd, opcode, operand_lo, operand_hi, instr_valid, pc,
    input  mem_ready, mem_data, instr_len, instr_ack, pc_load, pc_load_value
  );

  modport slave (
    input  mem_addr, mem_rd, opcode, operand_lo, operand_hi, instr_valid, pc,
    output mem_ready, mem_data, instr_len, instr_ack, pc_load, pc_load_value
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// 6502 front end: owns the PC, fetches opcode plus 0-2 operand bytes over a
// req/ready memory handshake and holds the bundle until execute acks it.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_DEC   = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_VALID = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] pc_q;
  logic [7:0]  opcode_q;
  logic [7:0]  operand_lo_q;
  logic [7:0]  operand_hi_q;
  logic        len3_q;
  logic        mem_rd_q;
  logic        instr_valid_q;
  logic        take;

  function automatic logic [15:0] pc_inc(input logic [15:0] p);
    return p + 16'd1;
  endfunction

  function automatic logic rd_state(input state_t s);
    return (s == S_OP) || (s == S_LO) || (s == S_HI);
  endfunction

  // A byte is only accepted while our own request is registered high; this
  // also keeps the first post-reset cycle (mem_rd still low) from consuming data.
  always_comb take = mem_rd_q && bus.mem_ready;

  always_comb begin
    state_nx = state;
    if (bus.pc_load) begin
      state_nx = S_OP;
    end else begin
      case (state)
        S_OP:    if (take) state_nx = S_DEC;
        S_DEC:   state_nx = bus.instr_len[1] ? S_LO : S_VALID;
        S_LO:    if (take) state_nx = len3_q ? S_HI : S_VALID;
        S_HI:    if (take) state_nx = S_VALID;
        S_VALID: if (bus.instr_ack) state_nx = S_OP;
        default: state_nx = S_OP;
      endcase
    end
  end

  // Control: state plus the registered request/valid strobes derived from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_OP;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state         <= state_nx;
      mem_rd_q      <= rd_state(state_nx);
      instr_valid_q <= (state_nx == S_VALID);
    end
  end

  // Datapath: PC and instruction bundle; a redirect leaves the bundle untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      opcode_q     <= 8'h00;
      operand_lo_q <= 8'h00;
      operand_hi_q <= 8'h00;
      len3_q       <= 1'b0;
    end else if (bus.pc_load) begin
      pc_q <= bus.pc_load_value;
    end else begin
      case (state)
        S_OP: begin
          if (take) begin
            opcode_q     <= bus.mem_data;
            operand_lo_q <= 8'h00;
            operand_hi_q <= 8'h00;
            pc_q         <= pc_inc(pc_q);
          end
        end
        S_DEC: len3_q <= (bus.instr_len == 2'd3);
        S_LO: begin
          if (take) begin
            operand_lo_q <= bus.mem_data;
            pc_q         <= pc_inc(pc_q);
          end
        end
        S_HI: begin
          if (take) begin
            operand_hi_q <= bus.mem_data;
            pc_q         <= pc_inc(pc_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand_lo  = operand_lo_q;
  assign bus.operand_hi  = operand_hi_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized instruction
// streams checked against an instruction-level memory/length model.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  instr_fetch_if bus ();

  instr_fetch_unit #(.RESET_PC(16'h0200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem     [0:65535];
  logic [1:0] len_tab [0:255];
  int         checks = 0;
  int         errors  = 0;
  bit         wait_rand = 1'b0;
  int         fix_wait  = 0;

  assign bus.instr_len = len_tab[bus.opcode];

  // Memory responder: each new request waits a number of cycles, then answers.
  bit          active = 1'b0;
  logic [15:0] cur_addr = 16'h0000;
  int          cnt = 0;
  int          tgt = 0;
  always begin
    @(posedge clk);
    #1;
    if (!bus.mem_rd) begin
      active        = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_data  = 8'($urandom);
    end else begin
      if (!active || bus.mem_addr != cur_addr) begin
        active   = 1'b1;
        cur_addr = bus.mem_addr;
        cnt      = 0;
        tgt      = wait_rand ? int'($urandom_range(0, 3)) : fix_wait;
      end else begin
        cnt++;
      end
      bus.mem_ready = (cnt >= tgt);
      bus.mem_data  = bus.mem_ready ? mem[bus.mem_addr] : 8'($urandom);
      if (bus.mem_ready) active = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what a complete instruction starting at p looks like.
  function automatic void predict(input logic [15:0] p, output logic [7:0] op,
                                  output logic [7:0] lo, output logic [7:0] hi,
                                  output logic [15:0] np);
    int n;
    op = mem[p];
    n  = int'(len_tab[op]);
    if (n == 0) n = 1;
    lo = (n >= 2) ? mem[p + 16'd1] : 8'h00;
    hi = (n == 3) ? mem[p + 16'd2] : 8'h00;
    np = p + 16'(n);
  endfunction

  task automatic wait_valid(input int budget);
    bit          seen = 1'b0;
    logic        pr_rd = 1'b0;
    logic        pr_rdy = 1'b0;
    logic [15:0] pr_addr = 16'h0000;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.instr_valid) seen = 1'b1;
      else if (pr_rd && !pr_rdy && bus.mem_rd) chk("addr_hold", bus.mem_addr, pr_addr);
      pr_rd   = bus.mem_rd;
      pr_rdy  = bus.mem_ready;
      pr_addr = bus.mem_addr;
    end
    chk("valid_seen", 16'(seen), 16'h0001);
  endtask

  task automatic check_bundle(input string tag, input logic [15:0] start);
    logic [7:0]  op, lo, hi;
    logic [15:0] np;
    predict(start, op, lo, hi, np);
    chk({tag, "_op"}, 16'(bus.opcode), 16'(op));
    chk({tag, "_lo"}, 16'(bus.operand_lo), 16'(lo));
    chk({tag, "_hi"}, 16'(bus.operand_hi), 16'(hi));
    chk({tag, "_pc"}, bus.pc, np);
  endtask

  task automatic redirect(input logic [15:0] a);
    bus.pc_load       = 1'b1;
    bus.pc_load_value = a;
    @(negedge clk);
    bus.pc_load = 1'b0;
  endtask

  initial begin
    logic [7:0]  op, lo, hi, keep_op;
    logic [15:0] np, exp_pc, tgt_pc;
    bit          found;

    reset             = 1'b1;
    bus.instr_ack     = 1'b0;
    bus.pc_load       = 1'b0;
    bus.pc_load_value = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) len_tab[i] = 2'($urandom);
    mem[16'h0200] = 8'hEA; len_tab[8'hEA] = 2'd1;
    mem[16'h0300] = 8'hAD; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12; len_tab[8'hAD] = 2'd3;
    len_tab[8'hA9] = 2'd2;
    mem[16'h0400] = 8'h20; mem[16'h0401] = 8'h11; mem[16'h0402] = 8'h22; len_tab[8'h20] = 2'd3;
    mem[16'hFFFF] = 8'h85; mem[16'h0000] = 8'h77; len_tab[8'h85] = 2'd2;
    mem[16'h0500] = 8'hA9; mem[16'h0501] = 8'h66;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", bus.pc, 16'h0200);
    chk("rst_op", 16'(bus.opcode), 16'h0000);
    chk("rst_lo", 16'(bus.operand_lo), 16'h0000);
    chk("rst_hi", 16'(bus.operand_hi), 16'h0000);
    chk("rst_valid", 16'(bus.instr_valid), 16'h0000);
    chk("rst_rd", 16'(bus.mem_rd), 16'h0000);

    // 1-byte NOP at reset vector, zero-wait memory, ack held high
    bus.instr_ack = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("t1_rd", 16'(bus.mem_rd), 16'h0001);
    chk("t1_addr", bus.mem_addr, 16'h0200);
    @(negedge clk);
    chk("t1_dec_valid", 16'(bus.instr_valid), 16'h0000);
    chk("t1_dec_rd", 16'(bus.mem_rd), 16'h0000);
    @(negedge clk);
    chk("t1_valid", 16'(bus.instr_valid), 16'h0001);
    check_bundle("t1", 16'h0200);
    @(negedge clk);
    chk("t1_next_rd", 16'(bus.mem_rd), 16'h0001);
    chk("t1_next_addr", bus.mem_addr, 16'h0201);
    chk("t1_next_valid", 16'(bus.instr_valid), 16'h0000);
    bus.instr_ack = 1'b0;

    // 3-byte instruction with 2 wait cycles per byte
    fix_wait = 2;
    redirect(16'h0300);
    wait_valid(40);
    check_bundle("t2", 16'h0300);

    // 2-byte instruction held while ack stays low
    mem[16'h0300] = 8'hA9; mem[16'h0301] = 8'h55;
    fix_wait = 0;
    redirect(16'h0300);
    wait_valid(40);
    check_bundle("t3", 16'h0300);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 16'(bus.instr_valid), 16'h0001);
      chk("t3_hold_rd", 16'(bus.mem_rd), 16'h0000);
      chk("t3_hold_op", 16'(bus.opcode), 16'h00A9);
      chk("t3_hold_lo", 16'(bus.operand_lo), 16'h0055);
    end
    bus.instr_ack = 1'b1;
    @(negedge clk);
    bus.instr_ack = 1'b0;
    chk("t3_ack_valid", 16'(bus.instr_valid), 16'h0000);
    chk("t3_ack_rd", 16'(bus.mem_rd), 16'h0001);
    chk("t3_ack_addr", bus.mem_addr, 16'h0302);

    // Redirect in the S_HI wait, coinciding with the operand's mem_ready
    fix_wait = 2;
    redirect(16'h0400);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.mem_rd && bus.mem_ready && bus.mem_addr == 16'h0402) found = 1'b1;
      else @(negedge clk);
    end
    chk("t4_hi_reached", 16'(found), 16'h0001);
    redirect(16'h8000);
    chk("t4_addr", bus.mem_addr, 16'h8000);
    chk("t4_rd", 16'(bus.mem_rd), 16'h0001);
    chk("t4_valid", 16'(bus.instr_valid), 16'h0000);
    chk("t4_hi_kept", 16'(bus.operand_hi), 16'h0000);
    chk("t4_lo_kept", 16'(bus.operand_lo), 16'h0011);
    wait_valid(40);
    check_bundle("t4", 16'h8000);

    // 2-byte instruction straddling the top of the address space
    fix_wait = 0;
    redirect(16'hFFFF);
    chk("t5_valid_drop", 16'(bus.instr_valid), 16'h0000);
    wait_valid(40);
    check_bundle("t5", 16'hFFFF);

    // Randomized streams with random waits, ack delays and redirects
    wait_rand = 1'b1;
    exp_pc = 16'($urandom);
    redirect(exp_pc);
    for (int k = 0; k < 60; k++) begin
      wait_valid(60);
      check_bundle("rnd", exp_pc);
      predict(exp_pc, op, lo, hi, np);
      keep_op = bus.opcode;
      for (int h = $urandom_range(0, 3); h > 0; h--) begin
        @(negedge clk);
        chk("rnd_hold_valid", 16'(bus.instr_valid), 16'h0001);
        chk("rnd_hold_op", 16'(bus.opcode), 16'(keep_op));
      end
      if ($urandom_range(0, 4) == 0) begin
        tgt_pc = 16'($urandom);
        bus.instr_ack = 1'($urandom_range(0, 1));
        redirect(tgt_pc);
        bus.instr_ack = 1'b0;
        chk("rnd_redir_addr", bus.mem_addr, tgt_pc);
        chk("rnd_redir_valid", 16'(bus.instr_valid), 16'h0000);
        exp_pc = tgt_pc;
      end else begin
        bus.instr_ack = 1'b1;
        @(negedge clk);
        bus.instr_ack = 1'b0;
        chk("rnd_ack_valid", 16'(bus.instr_valid), 16'h0000);
        chk("rnd_ack_addr", bus.mem_addr, np);
        chk("rnd_ack_rd", 16'(bus.mem_rd), 16'h0001);
        exp_pc = np;
      end
    end

    // Async reset between edges while waiting on the operand byte
    wait_rand = 1'b0;
    fix_wait  = 3;
    redirect(16'h0500);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.mem_rd && bus.mem_addr == 16'h0501) found = 1'b1;
      else @(negedge clk);
    end
    chk("t6_lo_reached", 16'(found), 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_pc", bus.pc, 16'h0200);
    chk("t6_op", 16'(bus.opcode), 16'h0000);
    chk("t6_lo", 16'(bus.operand_lo), 16'h0000);
    chk("t6_hi", 16'(bus.operand_hi), 16'h0000);
    chk("t6_valid", 16'(bus.instr_valid), 16'h0000);
    chk("t6_rd", 16'(bus.mem_rd), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_restart_rd", 16'(bus.mem_rd), 16'h0001);
    chk("t6_restart_addr", bus.mem_addr, 16'h0200);
    wait_valid(40);
    check_bundle("t6", 16'h0200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 6502 core.
- Owns the 16-bit program counter and fetches the opcode plus 0–2 operand bytes from memory over a req/ready handshake.
- Presents a complete instruction (opcode, operand_lo, operand_hi) to the decode/execute stage, which loads them into its 8-bit registers.
- Holds the instruction until the consumer acknowledges it, and supports PC redirection for jumps and branches.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr  output  16  read address; equals current PC while mem_rd=1.
- mem_rd  output  1  read request.
- mem_ready  input  1  read data valid this cycle; sampled only when mem_rd=1.
- mem_data  input  8  read data, valid when mem_ready=1.
- opcode  output  8  latched opcode byte.
- operand_lo  output  8  first operand byte; 8'h00 if absent.
- operand_hi  output  8  second operand byte; 8'h00 if absent.
- instr_len  input  2  instruction length in bytes, from the external combinational decoder driven by `opcode`; 0 is treated as 1, 3 means 3.
- instr_valid  output  1  instruction bundle is complete and stable.
- instr_ack  input  1  consumer accepts the bundle; effective only when instr_valid=1.
- pc_load  input  1  redirect PC.
- pc_load_value  input  16  new PC value.
- pc  output  16  current PC.

Behaviour:
- Reset (async, any state):
  - State S_OP, pc=RESET_PC.
  - opcode, operand_lo, operand_hi = 8'h00.
  - instr_valid=0. mem_rd rises in the first cycle after reset deasserts.
- States: S_OP, S_DEC, S_LO, S_HI, S_VALID.
- S_OP:
  - mem_rd=1, mem_addr=pc.
  - On mem_ready: opcode<=mem_data, operand_lo/hi<=8'h00, pc<=pc+1, go to S_DEC.
  - Otherwise hold, with mem_rd and mem_addr stable.
- S_DEC (exactly 1 cycle, mem_rd=0):
  - Sample instr_len. Length 0 or 1 → S_VALID; 2 or 3 → S_LO.
  - Latch the sampled length internally; instr_len is ignored afterwards.
- S_LO:
  - mem_rd=1.
  - On mem_ready: operand_lo<=mem_data, pc<=pc+1. Then S_HI if latched length is 3, else S_VALID.
- S_HI:
  - mem_rd=1.
  - On mem_ready: operand_hi<=mem_data, pc<=pc+1, go to S_VALID.
- S_VALID:
  - instr_valid=1, mem_rd=0. Bundle outputs must not change.
  - On instr_ack: go to S_OP; instr_valid drops the next cycle.
  - Minimum gap between consecutive instr_valid pulses is 2 cycles (S_OP with a zero-wait memory, then S_DEC).
- Latency with zero-wait memory, counted from entry to S_OP until instr_valid is asserted:
  - 1-byte instruction: 2 cycles.
  - 2-byte instruction: 3 cycles.
  - 3-byte instruction: 4 cycles.
- PC arithmetic: 16-bit modulo; 16'hFFFF+1 → 16'h0000, with no flag.
- pc_load (any state, highest priority after reset):
  - pc<=pc_load_value, state<=S_OP.
  - In-flight fetch is abandoned; mem_ready in the same cycle is ignored.
  - instr_valid drops the next cycle; bundle registers keep their old values until overwritten.
  - pc_load together with instr_ack: pc_load wins, and the ack has no additional effect.
- instr_ack outside S_VALID is ignored. mem_ready while mem_rd=0 is ignored.
- mem_rd may drop without mem_ready (abort by pc_load or reset); memory must tolerate abandoned requests.
- Outputs are registered or decoded directly from state; there are no combinational paths from mem_data to any output.

Test Plan:
- Reset with RESET_PC=16'h0200, zero-wait memory holding EA at 0200, instr_len=1, ack held high → mem_addr 0200, opcode=EA, operand_lo/hi=00, instr_valid two cycles after first mem_rd, next fetch at 0201.
- Memory AD 34 12 at 0300, instr_len=3, mem_ready delayed 2 cycles per byte → opcode=AD, lo=34, hi=12, pc=0303, mem_addr stable during each wait.
- Bundle valid, instr_ack held low 5 cycles → instr_valid stays 1, outputs unchanged, mem_rd=0 throughout; ack → S_OP at 0302 (2-byte instr at 0300).
- pc_load=1, value 16'h8000, during the S_HI wait with mem_ready in the same cycle → byte discarded, instr_valid never asserted for that instruction, next mem_addr=8000.
- 2-byte instruction at 16'hFFFF (opcode at FFFF, operand at 0000) → operand fetched from 0000, pc=0001 afterwards.
- Async reset asserted mid-S_LO between clock edges → outputs clear immediately, pc=RESET_PC, and fetch restarts at S_OP after release.
